lfsr_range_gen: RTL and testbench
=================================

LFSR_RANGE_GEN -- requirements
Module: lfsr_range_gen

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
- WIDTH, 8, LFSR length in bits; legal range 3..16.
- OUT_W, 5, output width in bits; OUT_W <= WIDTH.
- RANGE_MIN, 2, lowest value data may take.
- RANGE_MAX, 20, highest value data may take; RANGE_MIN <= RANGE_MAX < 2^OUT_W.
- MAX_TRIES, 8, maximum sample attempts per request; at least 1.
- SEED, 1, LFSR value after reset; a value of 0 is replaced by 1.

REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- rst, in, 1, reset; synchronous, active-high.
- seed_load, in, 1, load seed_in into the LFSR.
- seed_in, in, WIDTH, seed value.
- req, in, 1, request one ranged random value.
- ack, in, 1, consumer has taken data.
- data, out, OUT_W, ranged random value.
- valid, out, 1, data is valid.
- lfsr_state, out, WIDTH, current LFSR register.

REQ-003 All outputs SHALL be registered.

Function
REQ-004 LFSR update:
- Fibonacci form, shift-left: next = {state[WIDTH-2:0], fb}.
- fb is the XOR of the tap bits (1-based).
- The LFSR SHALL advance every cycle unless rst or seed_load is high.

REQ-005 Taps by WIDTH (maximal length):
- 3:3,2; 4:4,3; 5:5,3; 6:6,5; 7:7,6; 8:8,6,5,4; 9:9,5; 10:10,7
- 11:11,9; 12:12,11,10,4; 13:13,12,11,8; 14:14,13,12,2; 15:15,14; 16:16,15,13,4

REQ-006 Lock-up guard: any load (seed or reset) of all-zeros SHALL store 1 instead, so the period is 2^WIDTH-1.

REQ-007 The FSM SHALL have three states: IDLE, SAMPLE and HOLD; reset state is IDLE.

REQ-008 IDLE:
- req=1 -> SAMPLE on the next cycle, with the try counter cleared.

REQ-009 SAMPLE, each cycle:
- candidate = lfsr_state[OUT_W-1:0], the current-cycle value.
- candidate <= RANGE_MAX-RANGE_MIN -> data <= candidate+RANGE_MIN; go to HOLD.
- Otherwise increment the try counter.
- On the MAX_TRIES-th reject -> data <= RANGE_MIN (fallback); go to HOLD.

REQ-010 HOLD:
- valid=1; data SHALL stay stable.
- ack=1 -> IDLE, with valid=0 from the next cycle.

REQ-011 Latency:
- req high in IDLE at cycle r -> valid high at cycle r+1+k, where k (1..MAX_TRIES) is the number of SAMPLE cycles.
- Minimum latency is 2 cycles.

REQ-012 req while in SAMPLE or HOLD SHALL be ignored; requests SHALL NOT be queued.

REQ-013 ack outside HOLD SHALL be ignored.

REQ-014 Same-cycle req and ack in HOLD SHALL go to IDLE only; the new req is dropped.

REQ-015 seed_load=1 (when rst=0), from the next cycle:
- lfsr_state = seed_in (0 -> 1).
- FSM = IDLE, valid=0, try counter cleared.
- Any in-flight request is aborted.
- data keeps its last value.

REQ-016 seed_load has priority over req and ack in the same cycle.

REQ-017 data SHALL always lie in [RANGE_MIN, RANGE_MAX].

REQ-018 All arithmetic SHALL be unsigned; the range offset SHALL be computed at OUT_W+1 bits with no truncation.

Reset
REQ-019 rst=1 at a clock edge SHALL set lfsr_state=SEED (0 -> 1), FSM=IDLE, valid=0, data=RANGE_MIN and try counter=0.

REQ-020 rst SHALL take priority over seed_load, req and ack.

REQ-021 rst asserted mid-request SHALL abort the request with no valid pulse.

Verification
REQ-022 Bench configuration is WIDTH=5, OUT_W=5, RANGE_MIN=2, RANGE_MAX=20, unless a scenario states otherwise.

REQ-023 The bench SHALL cover these directed scenarios:
- Sequence: seed_load with seed_in=5'h01 -> lfsr_state = 01,02,04,09,12,05,... and returns to 01 after exactly 31 cycles with no repeat earlier.
- Zero seed: seed_load with seed_in=0 -> lfsr_state=1 the next cycle; the sequence never reaches 0 over 100 cycles.
- Rejection: seed_load 5'h0F, then req the next cycle -> SAMPLE sees candidates 31,30,28,24,17 -> valid rises 6 cycles after req with data=19 and holds until ack.
- Fallback: MAX_TRIES=1, seed_load 5'h0F, then req -> candidate 31 rejected -> valid 2 cycles after req, data=2.
- Handshake: req held high through HOLD, with ack after 3 cycles -> one valid episode only; valid=0 the cycle after ack; req re-sampled afterwards.
- Abort: seed_load, and separately rst, asserted in SAMPLE and in HOLD -> valid=0 next cycle, FSM=IDLE; after rst, lfsr_state=SEED and data=2.
- Random: 10k random req/ack/seed_load mix -> data always in [2,20], and every valid is preceded by exactly one accepted req.

Source files
------------

// File: rtl/lfsr_range_gen.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_range_gen
// Purpose  : Fibonacci LFSR with rejection-sampled, range-limited output
//            delivered over a req / valid / ack handshake.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_range_gen #(
    parameter int WIDTH     = 8,
    parameter int OUT_W     = 5,
    parameter int RANGE_MIN = 2,
    parameter int RANGE_MAX = 20,
    parameter int MAX_TRIES = 8,
    parameter int SEED      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req,
    input  logic             ack,
    output logic [OUT_W-1:0] data,
    output logic             valid,
    output logic [WIDTH-1:0] lfsr_state
);

    // Tap masks: bit (n-1) set for 1-based tap n, maximal-length polynomials.
    function automatic logic [15:0] f_taps(input int w);
        case (w)
            3:       f_taps = 16'h0006;
            4:       f_taps = 16'h000C;
            5:       f_taps = 16'h0014;
            6:       f_taps = 16'h0030;
            7:       f_taps = 16'h0060;
            8:       f_taps = 16'h00B8;
            9:       f_taps = 16'h0110;
            10:      f_taps = 16'h0240;
            11:      f_taps = 16'h0500;
            12:      f_taps = 16'h0E08;
            13:      f_taps = 16'h1C80;
            14:      f_taps = 16'h3802;
            15:      f_taps = 16'h6000;
            16:      f_taps = 16'hD008;
            default: f_taps = 16'h0006;
        endcase
    endfunction

    localparam int               c_TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [c_TRY_W-1:0] c_LAST_TRY = c_TRY_W'(MAX_TRIES - 1);
    localparam logic [15:0]      c_TAPS_ALL = f_taps(WIDTH);
    localparam logic [WIDTH-1:0] c_TAPS     = c_TAPS_ALL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] c_SEED_RAW = WIDTH'(SEED);
    localparam logic [WIDTH-1:0] c_SEED     = (c_SEED_RAW == '0) ? WIDTH'(1) : c_SEED_RAW;
    localparam logic [OUT_W:0]   c_MIN      = (OUT_W + 1)'(RANGE_MIN);
    localparam logic [OUT_W:0]   c_MAX      = (OUT_W + 1)'(RANGE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_lfsr;
    logic [OUT_W-1:0]     r_data;
    logic                 r_valid;
    logic [c_TRY_W-1:0]   r_tries;

    logic                 w_fb;
    logic [WIDTH-1:0]     w_lfsr_next;
    logic [WIDTH-1:0]     w_seed_ld;
    logic [OUT_W:0]       w_offset;
    logic                 w_in_range;

    assign w_fb        = ^(r_lfsr & c_TAPS);
    assign w_lfsr_next = {r_lfsr[WIDTH-2:0], w_fb};
    assign w_seed_ld   = (seed_in == '0) ? WIDTH'(1) : seed_in;

    // Offset is formed one bit wider so candidate+MIN never wraps; the range
    // test on the sum is then equivalent to candidate <= MAX-MIN.
    assign w_offset    = {1'b0, r_lfsr[OUT_W-1:0]} + c_MIN;
    assign w_in_range  = (w_offset <= c_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr  <= c_SEED;
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_data  <= c_MIN[OUT_W-1:0];
            r_tries <= '0;
        end else if (seed_load) begin
            r_lfsr  <= w_seed_ld;
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_tries <= '0;
        end else begin
            r_lfsr <= w_lfsr_next;
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_state <= SAMPLE;
                        r_tries <= '0;
                    end
                end
                SAMPLE: begin
                    if (w_in_range) begin
                        r_data  <= w_offset[OUT_W-1:0];
                        r_valid <= 1'b1;
                        r_state <= HOLD;
                    end else if (r_tries == c_LAST_TRY) begin
                        r_data  <= c_MIN[OUT_W-1:0];
                        r_valid <= 1'b1;
                        r_state <= HOLD;
                    end else begin
                        r_tries <= r_tries + 1'b1;
                    end
                end
                HOLD: begin
                    if (ack) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign data       = r_data;
    assign valid      = r_valid;
    assign lfsr_state = r_lfsr;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_range_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_range_gen
// Purpose  : Self-checking bench for lfsr_range_gen against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr_range_gen;

    localparam int c_W     = 5;
    localparam int c_OW    = 5;
    localparam int c_RMIN  = 2;
    localparam int c_RMAX  = 20;
    localparam int c_TRIES = 8;
    localparam int c_SEED  = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            seed_load;
    logic [c_W-1:0]  seed_in;
    logic            req;
    logic            ack;
    logic [c_OW-1:0] data;
    logic            valid;
    logic [c_W-1:0]  lfsr_state;
    logic [c_OW-1:0] data1;
    logic            valid1;
    logic [c_W-1:0]  lfsr1;

    int n_total = 0;
    int n_bad   = 0;

    // model: phase 0 idle, 1 sampling, 2 holding
    int m_lfsr, m_phase, m_left, m_pend, m_data, m_valid, m_done;
    int rises;
    logic prev_valid;

    always #5 clk = ~clk;

    lfsr_range_gen #(
        .WIDTH(c_W), .OUT_W(c_OW), .RANGE_MIN(c_RMIN), .RANGE_MAX(c_RMAX),
        .MAX_TRIES(c_TRIES), .SEED(c_SEED)
    ) dut (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in),
        .req(req), .ack(ack), .data(data), .valid(valid), .lfsr_state(lfsr_state)
    );

    lfsr_range_gen #(
        .WIDTH(c_W), .OUT_W(c_OW), .RANGE_MIN(c_RMIN), .RANGE_MAX(c_RMAX),
        .MAX_TRIES(1), .SEED(c_SEED)
    ) dut1 (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in),
        .req(req), .ack(ack), .data(data1), .valid(valid1), .lfsr_state(lfsr1)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // x^5 + x^3 + 1 written arithmetically: shift left mod 32, feed bit4^bit2
    function automatic int lnext(input int s);
        return ((s * 2) % 32) + (((s / 16) + (s / 4)) % 2);
    endfunction

    // Outcome of a request accepted while the LFSR holds L
    task automatic predict(input int lval, output int k, output int d);
        int  s;
        bit  found;
        s = lval; k = c_TRIES; d = c_RMIN; found = 0;
        for (int j = 1; j <= c_TRIES; j++) begin
            s = lnext(s);
            if (!found && (s % 32) <= (c_RMAX - c_RMIN)) begin
                found = 1; k = j; d = (s % 32) + c_RMIN;
            end
        end
    endtask

    task automatic model_edge(input logic r, input logic a, input logic sl,
                              input logic [4:0] sd, input logic rs);
        int k, d;
        if (rs) begin
            m_lfsr = (c_SEED == 0) ? 1 : c_SEED;
            m_phase = 0; m_valid = 0; m_data = c_RMIN;
        end else if (sl) begin
            m_lfsr = (sd == 0) ? 1 : int'(sd);
            m_phase = 0; m_valid = 0;
        end else begin
            case (m_phase)
                0: if (r) begin
                    predict(m_lfsr, k, d);
                    m_left = k; m_pend = d; m_phase = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = 2; m_valid = 1; m_data = m_pend; m_done++;
                    end
                end
                default: if (a) begin
                    m_phase = 0; m_valid = 0;
                end
            endcase
            m_lfsr = lnext(m_lfsr);
        end
    endtask

    task automatic cycle(input logic r, input logic a, input logic sl,
                         input logic [4:0] sd, input logic rs);
        req = r; ack = a; seed_load = sl; seed_in = sd; rst = rs;
        @(posedge clk);
        model_edge(r, a, sl, sd, rs);
        @(negedge clk);
        check_eq("lfsr", 32'(lfsr_state), 32'(m_lfsr));
        check_eq("valid", 32'(valid), 32'(m_valid));
        check_eq("data", 32'(data), 32'(m_data));
        check_eq("range", 32'(data >= c_RMIN && data <= c_RMAX), 32'd1);
        if (valid && !prev_valid) begin
            rises++;
            check_eq("one_req_per_valid", 32'(rises), 32'(m_done));
        end
        prev_valid = valid;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 5'd0, 0);
    endtask

    // seed_load 0F then req: lands in the first SAMPLE cycle
    task automatic start_0f_req();
        cycle(0, 0, 1, 5'h0F, 0);
        cycle(1, 0, 0, 5'd0, 0);
    endtask

    initial begin
        logic [4:0] exp_seq [5];
        bit         seen [32];
        int         t;

        exp_seq = '{5'h02, 5'h04, 5'h09, 5'h12, 5'h05};
        m_lfsr = c_SEED; m_phase = 0; m_left = 0; m_pend = 0;
        m_data = c_RMIN; m_valid = 0; m_done = 0; rises = 0; prev_valid = 1'b0;
        req = 0; ack = 0; seed_load = 0; seed_in = '0; rst = 1;

        // reset
        cycle(0, 0, 0, 5'd0, 1);
        cycle(1, 1, 1, 5'h0F, 1);
        check_eq("rst_lfsr", 32'(lfsr_state), 32'd1);
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_data", 32'(data), 32'd2);

        // sequence from seed 1: period 31, no early repeat
        for (int i = 0; i < 32; i++) seen[i] = 0;
        cycle(0, 0, 1, 5'h01, 0);
        check_eq("seq_start", 32'(lfsr_state), 32'd1);
        seen[1] = 1;
        for (int i = 1; i <= 31; i++) begin
            idle(1);
            if (i <= 5) check_eq("seq_val", 32'(lfsr_state), 32'(exp_seq[i-1]));
            if (i < 31) begin
                check_eq("seq_no_repeat", 32'(seen[lfsr_state]), 32'd0);
                seen[lfsr_state] = 1;
            end else begin
                check_eq("seq_period", 32'(lfsr_state), 32'd1);
            end
        end

        // zero seed is replaced by 1 and never reaches 0
        cycle(0, 0, 1, 5'h00, 0);
        check_eq("zero_seed", 32'(lfsr_state), 32'd1);
        for (int i = 0; i < 100; i++) begin
            idle(1);
            check_eq("never_zero", 32'(lfsr_state == 0), 32'd0);
        end

        // rejection (8 tries) and fallback (1 try) side by side
        start_0f_req();
        for (int i = 1; i <= 6; i++) begin
            if (i > 1) idle(1);
            check_eq("rej_valid", 32'(valid), 32'(i == 6));
            check_eq("fb_valid", 32'(valid1), 32'(i >= 2));
            if (i == 2) check_eq("fb_data", 32'(data1), 32'd2);
        end
        check_eq("rej_data", 32'(data), 32'd19);
        idle(2);
        check_eq("rej_hold", 32'(data), 32'd19);
        cycle(0, 1, 0, 5'd0, 0);
        check_eq("rej_ack", 32'(valid), 32'd0);

        // handshake with req held through HOLD
        t = 0;
        while (!valid && t < 12) begin cycle(1, 0, 0, 5'd0, 0); t++; end
        check_eq("hs_first_valid", 32'(valid), 32'd1);
        cycle(1, 0, 0, 5'd0, 0);
        cycle(1, 0, 0, 5'd0, 0);
        cycle(1, 1, 0, 5'd0, 0);
        check_eq("hs_after_ack", 32'(valid), 32'd0);
        t = 0;
        while (!valid && t < 12) begin cycle(1, 0, 0, 5'd0, 0); t++; end
        check_eq("hs_resampled", 32'(valid), 32'd1);
        cycle(0, 1, 0, 5'd0, 0);

        // aborts: seed_load / rst in SAMPLE and in HOLD
        start_0f_req();
        cycle(0, 0, 1, 5'h03, 0);
        check_eq("sl_sample_valid", 32'(valid), 32'd0);
        check_eq("sl_sample_lfsr", 32'(lfsr_state), 32'd3);
        idle(8);
        check_eq("sl_sample_idle", 32'(valid), 32'd0);

        start_0f_req();
        idle(5);
        check_eq("sl_hold_pre", 32'(valid), 32'd1);
        cycle(0, 1, 1, 5'h07, 0);
        check_eq("sl_hold_valid", 32'(valid), 32'd0);
        check_eq("sl_hold_data", 32'(data), 32'd19);
        idle(8);

        start_0f_req();
        cycle(0, 0, 0, 5'd0, 1);
        check_eq("rst_sample_valid", 32'(valid), 32'd0);
        check_eq("rst_sample_lfsr", 32'(lfsr_state), 32'(c_SEED));
        idle(10);
        check_eq("rst_sample_idle", 32'(valid), 32'd0);

        start_0f_req();
        idle(5);
        cycle(1, 1, 1, 5'h09, 1);
        check_eq("rst_hold_valid", 32'(valid), 32'd0);
        check_eq("rst_hold_lfsr", 32'(lfsr_state), 32'(c_SEED));
        check_eq("rst_hold_data", 32'(data), 32'd2);

        // random mix
        for (int i = 0; i < 10000; i++) begin
            cycle(1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 49) == 0),
                  5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 199) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
